canframe_tx_scheduler: RTL and testbench

Sequences the test-bench CAN frame generator and shares it between N_REQ message requesters (index 0 custom, 1 SDO read, 2 SDO write, 3 ADC readout). It runs round-robin arbitration, selects the frame type, and holds the generator start for exactly the frame length in bit times. It then enforces an inter-frame space and signals completion to the winning requester. It sits between the test-bench state machine and the frame generator, in the single system clock domain.

---
 rtl/canframe_tx_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_canframe_tx_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/canframe_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : canframe_tx_scheduler
// Purpose  : Round-robin scheduler sharing one CAN frame generator between
//            N_REQ requesters; times gen_start, inter-frame space and done.
// Revision : 1.0 - initial release
// ============================================================================
module canframe_tx_scheduler #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned IFS_BITS   = 11,
    parameter int unsigned MAX_LEN    = 160
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             bit_tick,
    input  logic [N_REQ-1:0] req,
    input  logic [7:0]       frame_len,
    output logic [N_REQ-1:0] gen_sel,
    output logic             gen_start,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] done,
    output logic             err,
    output logic             busy,
    output logic [15:0]      frames_sent
);

    localparam int unsigned c_PW          = $clog2(N_REQ);
    localparam logic [3:0]  c_SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [3:0]  c_SETTLE_EVAL = 4'(SETTLE_CYC);
    localparam logic [5:0]  c_IFS_LAST    = 6'(IFS_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SEND = 3'd2,
        S_IFS  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            r_state;
    logic [c_PW-1:0]   r_rr_ptr;
    logic [c_PW-1:0]   r_idx;
    logic [N_REQ-1:0]  r_gnt;
    logic [N_REQ-1:0]  r_gen_sel;
    logic [N_REQ-1:0]  r_done;
    logic              r_gen_start;
    logic              r_err;
    logic              r_busy;
    logic [15:0]       r_frames_sent;
    logic [3:0]        r_settle;
    logic [7:0]        r_len_q;
    logic [7:0]        r_tick_cnt;
    logic [5:0]        r_ifs_cnt;

    int                w_idx;
    logic              w_found;
    logic [c_PW-1:0]   w_pick;
    logic [N_REQ-1:0]  w_pick_oh;
    logic [c_PW-1:0]   w_rr_next;
    logic              w_len_bad;

    // Search upward from the round-robin pointer, wrapping at N_REQ.
    always_comb begin
        w_idx   = 0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            w_idx = int'(r_rr_ptr) + i;
            if (w_idx >= int'(N_REQ)) begin
                w_idx = w_idx - int'(N_REQ);
            end
            if (!w_found && req[c_PW'(w_idx)]) begin
                w_found = 1'b1;
                w_pick  = c_PW'(w_idx);
            end
        end
    end

    assign w_pick_oh = N_REQ'(1) << w_pick;
    assign w_rr_next = (r_idx == c_PW'(N_REQ - 1)) ? '0 : r_idx + c_PW'(1);
    assign w_len_bad = (r_len_q == 8'd0) || (32'(r_len_q) > MAX_LEN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_idx         <= '0;
            r_gnt         <= '0;
            r_gen_sel     <= '0;
            r_done        <= '0;
            r_gen_start   <= 1'b0;
            r_err         <= 1'b0;
            r_busy        <= 1'b0;
            r_frames_sent <= 16'd0;
            r_settle      <= 4'd0;
            r_len_q       <= 8'd0;
            r_tick_cnt    <= 8'd0;
            r_ifs_cnt     <= 6'd0;
        end else begin
            r_done <= '0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable && w_found) begin
                        r_idx     <= w_pick;
                        r_gnt     <= w_pick_oh;
                        r_gen_sel <= w_pick_oh;
                        r_busy    <= 1'b1;
                        r_settle  <= 4'd0;
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (r_settle == c_SETTLE_LAST) begin
                        r_len_q <= frame_len;
                    end
                    // One cycle after the sample the latched length is judged.
                    if (r_settle == c_SETTLE_EVAL) begin
                        if (w_len_bad) begin
                            r_gen_sel <= '0;
                            r_done    <= r_gnt;
                            r_err     <= 1'b1;
                            r_rr_ptr  <= w_rr_next;
                            r_state   <= S_DONE;
                        end else begin
                            r_gen_start <= 1'b1;
                            r_tick_cnt  <= 8'd0;
                            r_state     <= S_SEND;
                        end
                    end else begin
                        r_settle <= r_settle + 4'd1;
                    end
                end
                S_SEND: begin
                    if (bit_tick) begin
                        if (r_tick_cnt == r_len_q - 8'd1) begin
                            r_gen_start <= 1'b0;
                            r_gen_sel   <= '0;
                            r_tick_cnt  <= 8'd0;
                            r_ifs_cnt   <= 6'd0;
                            r_state     <= S_IFS;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 8'd1;
                        end
                    end
                end
                S_IFS: begin
                    if (bit_tick) begin
                        if (r_ifs_cnt == c_IFS_LAST) begin
                            r_ifs_cnt     <= 6'd0;
                            r_done        <= r_gnt;
                            r_frames_sent <= r_frames_sent + 16'd1;
                            r_rr_ptr      <= w_rr_next;
                            r_state       <= S_DONE;
                        end else begin
                            r_ifs_cnt <= r_ifs_cnt + 6'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_gnt     <= '0;
                    r_gen_sel <= '0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gen_sel     = r_gen_sel;
    assign gen_start   = r_gen_start;
    assign gnt         = r_gnt;
    assign done        = r_done;
    assign err         = r_err;
    assign busy        = r_busy;
    assign frames_sent = r_frames_sent;

endmodule
`default_nettype wire

// File: tb/tb_canframe_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_canframe_tx_scheduler
// Purpose  : Directed bench for canframe_tx_scheduler with a transaction-level
//            reference model and per-cycle output comparison.
// Revision : 1.0 - initial release
// ============================================================================
module tb_canframe_tx_scheduler;

    localparam int c_N    = 4;
    localparam int c_S    = 2;
    localparam int c_IFS  = 11;
    localparam int c_MAXL = 160;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           enable = 1'b0;
    logic           bit_tick = 1'b0;
    logic [c_N-1:0] req = '0;
    logic [7:0]     frame_len = 8'd0;
    logic [c_N-1:0] gen_sel, gnt, done;
    logic           gen_start, err, busy;
    logic [15:0]    frames_sent;

    canframe_tx_scheduler #(
        .N_REQ(c_N), .SETTLE_CYC(c_S), .IFS_BITS(c_IFS), .MAX_LEN(c_MAXL)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .bit_tick(bit_tick),
        .req(req), .frame_len(frame_len), .gen_sel(gen_sel),
        .gen_start(gen_start), .gnt(gnt), .done(done), .err(err),
        .busy(busy), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Bit-time generator: one pulse every tick_div clocks.
    int tick_div = 8;
    int tick_ph  = 0;
    initial begin
        forever begin
            cyc();
            tick_ph  = (tick_ph + 1 >= tick_div) ? 0 : tick_ph + 1;
            bit_tick = (tick_ph == 0);
        end
    end

    // ---------------- reference model (transaction level) ----------------
    logic [c_N-1:0] exp_gnt = '0, exp_sel = '0, exp_done = '0;
    logic           exp_start = 1'b0, exp_err = 1'b0, exp_busy = 1'b0;
    logic [15:0]    exp_sent = 16'd0;
    int             m_rr = 0;
    bit             m_abort = 1'b0;
    bit             pre_flag = 1'b0;
    logic [15:0]    pre_val = 16'd0;

    task automatic m_step();
        @(posedge clk);
        if (rst) begin
            exp_gnt = '0; exp_sel = '0; exp_done = '0;
            exp_start = 1'b0; exp_err = 1'b0; exp_busy = 1'b0;
            exp_sent = 16'd0; m_rr = 0; m_abort = 1'b1;
        end
    endtask

    task automatic m_frame();
        int k, len, cnt;
        logic [c_N-1:0] oh;
        m_abort = 1'b0;
        forever begin
            m_step();
            if (m_abort) return;
            if (pre_flag) exp_sent = pre_val;
            if (enable && (req != '0)) break;
        end
        k = -1;
        for (int i = 0; i < c_N; i++) begin
            if (k < 0 && req[(m_rr + i) % c_N]) k = (m_rr + i) % c_N;
        end
        oh = c_N'(1) << k;
        exp_gnt = oh; exp_sel = oh; exp_busy = 1'b1;
        repeat (c_S) begin
            m_step();
            if (m_abort) return;
        end
        len = int'(frame_len);
        m_step();
        if (m_abort) return;
        if (len == 0 || len > c_MAXL) begin
            exp_sel = '0; exp_done = oh; exp_err = 1'b1;
            m_rr = (k + 1) % c_N;
        end else begin
            exp_start = 1'b1;
            cnt = 0;
            while (cnt < len) begin
                m_step();
                if (m_abort) return;
                if (bit_tick) cnt++;
            end
            exp_start = 1'b0; exp_sel = '0;
            cnt = 0;
            while (cnt < c_IFS) begin
                m_step();
                if (m_abort) return;
                if (bit_tick) cnt++;
            end
            exp_done = oh; exp_sent = exp_sent + 16'd1;
            m_rr = (k + 1) % c_N;
        end
        m_step();
        if (m_abort) return;
        exp_done = '0; exp_err = 1'b0; exp_gnt = '0; exp_sel = '0; exp_busy = 1'b0;
    endtask

    initial begin
        forever m_frame();
    end

    // ---------------- monitor and per-cycle compare ----------------
    bit             chk_en = 1'b0;
    bit             skip_sent = 1'b0;
    int             cyc_n = 0, grant_cyc = 0, done_cyc = 0, done_cnt = 0;
    int             send_ticks = 0, g_n = 0;
    bit             start_seen = 1'b0;
    int             g_log [0:63];
    logic [c_N-1:0] prev_gnt = '0, last_done = '0;
    logic           last_err = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc_n++;
            if (gnt != '0 && prev_gnt == '0) begin
                if (g_n < 64) g_log[g_n] = int'(gnt);
                g_n++;
                grant_cyc = cyc_n; send_ticks = 0; start_seen = 1'b0;
            end
            if (gen_start === 1'b1) start_seen = 1'b1;
            if (gen_start === 1'b1 && bit_tick) send_ticks++;
            if (done != '0) begin
                done_cnt++; last_done = done; last_err = err; done_cyc = cyc_n;
            end
            prev_gnt = gnt;
            if (chk_en) begin
                chk("gnt", 32'(gnt), 32'(exp_gnt));
                chk("gen_sel", 32'(gen_sel), 32'(exp_sel));
                chk("gen_start", 32'(gen_start), 32'(exp_start));
                chk("done", 32'(done), 32'(exp_done));
                chk("err", 32'(err), 32'(exp_err));
                chk("busy", 32'(busy), 32'(exp_busy));
                if (!skip_sent) chk("frames_sent", 32'(frames_sent), 32'(exp_sent));
            end
        end
    end

    task automatic wait_done(input int max_cyc, input string tag);
        int start_cnt, c;
        start_cnt = done_cnt;
        c = 0;
        while (done_cnt == start_cnt && c < max_cyc) begin
            cyc();
            c++;
        end
        if (done_cnt == start_cnt) begin
            n_total++;
            $display("FAIL %s: got no done pulse within %0d cycles, expected one", tag, max_cyc);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int b, c, d0;
        cyc();
        chk_en = 1'b1;
        cyc();
        chk("rst_frames_sent", 32'(frames_sent), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0; enable = 1'b1;
        cyc();

        // Single 108-bit frame, bit time of 8 clocks.
        frame_len = 8'd108; req = 4'b0001;
        cyc();
        chk("t1_grant_latency", 32'(gnt), 32'h1);
        req = 4'b0000;
        wait_done(1300, "t1_done");
        chk("t1_send_ticks", 32'(send_ticks), 32'd108);
        chk("t1_done_vec", 32'(last_done), 32'h1);
        chk("t1_err", 32'(last_err), 32'd0);
        chk("t1_frames_sent", 32'(frames_sent), 32'd1);
        cyc();

        // Two requesters held high alternate.
        tick_div = 2; frame_len = 8'd20; req = 4'b0110;
        b = g_n;
        for (int f = 0; f < 4; f++) wait_done(300, "t2_done");
        req = 4'b0000;
        chk("t2_grant0", 32'(g_log[b]), 32'h2);
        chk("t2_grant1", 32'(g_log[b + 1]), 32'h4);
        chk("t2_grant2", 32'(g_log[b + 2]), 32'h2);
        chk("t2_grant3", 32'(g_log[b + 3]), 32'h4);
        chk("t2_frames_sent", 32'(frames_sent), 32'd5);
        cyc();

        // Zero length: skipped with err, rr_ptr 3 wraps to requester 0.
        frame_len = 8'd0; req = 4'b0001;
        cyc();
        req = 4'b0000;
        wait_done(40, "t3_done");
        chk("t3_done_latency", 32'(done_cyc - grant_cyc), 32'(c_S + 1));
        chk("t3_done_vec", 32'(last_done), 32'h1);
        chk("t3_err", 32'(last_err), 32'd1);
        chk("t3_no_start", 32'(start_seen), 32'd0);
        chk("t3_frames_sent", 32'(frames_sent), 32'd5);
        cyc(); cyc();

        // Oversize length, then a normal 64-bit frame.
        frame_len = 8'd200; req = 4'b0100;
        cyc();
        req = 4'b0000;
        wait_done(40, "t4a_done");
        chk("t4a_err", 32'(last_err), 32'd1);
        cyc(); cyc();
        frame_len = 8'd64; req = 4'b0100;
        cyc();
        req = 4'b0000;
        repeat (c_S + 1) cyc();
        frame_len = 8'd255;
        wait_done(400, "t4b_done");
        chk("t4b_err", 32'(last_err), 32'd0);
        chk("t4b_send_ticks", 32'(send_ticks), 32'd64);
        chk("t4b_frames_sent", 32'(frames_sent), 32'd6);
        cyc(); cyc();

        // Reset in the middle of a frame.
        frame_len = 8'd108; req = 4'b0001;
        cyc();
        req = 4'b0000;
        c = 0;
        while (send_ticks < 50 && c < 400) begin
            cyc();
            c++;
        end
        if (send_ticks < 50) begin
            n_total++;
            $display("FAIL t5_tick50: got %0d ticks, expected 50", send_ticks);
        end
        d0 = done_cnt;
        rst = 1'b1;
        cyc();
        chk("t5_rst_start", 32'(gen_start), 32'd0);
        chk("t5_rst_gnt", 32'(gnt), 32'd0);
        chk("t5_rst_frames", 32'(frames_sent), 32'd0);
        rst = 1'b0; frame_len = 8'd4; req = 4'b1001;
        cyc();
        chk("t5_rr_reset_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        chk("t5_no_done", 32'(done_cnt), 32'(d0));
        wait_done(100, "t5_done");
        chk("t5_frames_sent", 32'(frames_sent), 32'd1);
        cyc();

        // enable gates new grants only.
        enable = 1'b0; req = 4'b0010;
        repeat (6) cyc();
        chk("t6_blocked", 32'(gnt), 32'd0);
        enable = 1'b1;
        cyc();
        chk("t6_granted", 32'(gnt), 32'h2);
        enable = 1'b0; req = 4'b0000;
        wait_done(100, "t6_done");
        chk("t6_done_vec", 32'(last_done), 32'h2);
        enable = 1'b1;
        cyc();

        // frames_sent wrap from 0xFFFE through 0xFFFF to 0x0000.
        tick_div = 1; frame_len = 8'd1;
        skip_sent = 1'b1; pre_val = 16'hFFFE; pre_flag = 1'b1;
        force dut.r_frames_sent = 16'hFFFE;
        cyc();
        release dut.r_frames_sent;
        cyc();
        pre_flag = 1'b0; skip_sent = 1'b0;
        req = 4'b0001;
        cyc();
        req = 4'b0000;
        wait_done(60, "t7a_done");
        chk("t7_frames_ffff", 32'(frames_sent), 32'hFFFF);
        cyc(); cyc();
        req = 4'b0001;
        cyc();
        req = 4'b0000;
        wait_done(60, "t7b_done");
        chk("t7_frames_wrap", 32'(frames_sent), 32'h0000);
        chk("t7_err", 32'(last_err), 32'd0);

        repeat (3) cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
